// File: rtl/trdb_pkg.sv
// Shared constants and types for the trace-debugger timestamp unit.
package trdb_pkg;

    localparam int TRDB_TIMER_WIDTH = 40;

    // Slot record at the default timer width.
    typedef struct packed {
        logic                        full;
        logic [TRDB_TIMER_WIDTH-1:0] ts;
    } trdb_slot_t;

    // Channel id width; the extra code (n) tags the wrap marker.
    function automatic int trdb_ch_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/trdb_timestamp_unit_arb.sv
// N-input round-robin arbiter; the pick is frozen while the consumer stalls
// and the pointer moves past the winner when it is granted.
module trdb_rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req,
    input  logic          hold,
    input  logic          adv,
    output logic [IW-1:0] idx,
    output logic          any,
    output logic          locked
);

    logic [IW-1:0] ptr_q, idx_q, pick;
    logic          lock_q;

    always_comb begin
        int  k;
        logic found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr_q) + i;
            if (k >= N) k = k - N;
            if (!found && req[k]) begin
                found = 1'b1;
                pick  = IW'(k);
            end
        end
    end

    assign idx    = lock_q ? idx_q : pick;
    assign any    = |req;
    assign locked = lock_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q  <= '0;
            idx_q  <= '0;
            lock_q <= 1'b0;
        end else if (adv) begin
            lock_q <= 1'b0;
            ptr_q  <= (int'(idx) == N - 1) ? '0 : idx + IW'(1);
        end else if (hold) begin
            lock_q <= 1'b1;
            idx_q  <= idx;
        end
    end

endmodule

// File: rtl/trdb_timestamp_unit.sv
// Prescaled free-running timer with per-channel timestamp slots and a wrap
// marker, arbitrated onto one valid/grant packet port.
module trdb_timestamp_unit
    import trdb_pkg::*;
#(
    parameter int TIMER_WIDTH    = TRDB_TIMER_WIDTH,
    parameter int NUM_CH         = 2,
    parameter int PRESCALE_WIDTH = 8,
    parameter int CH_W           = trdb_ch_width(NUM_CH)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic [NUM_CH-1:0]         req_i,
    output logic [NUM_CH-1:0]         busy_o,
    output logic [NUM_CH:0]           drop_o,
    output logic                      valid_o,
    input  logic                      grant_i,
    output logic [TIMER_WIDTH-1:0]    time_o,
    output logic [CH_W-1:0]           ch_o,
    output logic [TIMER_WIDTH-1:0]    trdb_time_o
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef struct packed {
        logic                   full;
        logic [TIMER_WIDTH-1:0] ts;
    } slot_t;

    logic [PRESCALE_WIDTH-1:0] pre_q;
    logic [TIMER_WIDTH-1:0]    time_q;
    slot_t [NUM_CH-1:0]        slot_q;
    logic                      wrap_q, wlock_q;
    logic [NUM_CH:0]           drop_q;

    logic              tick, wrap_evt, sel_wrap, valid, accept, stall, wrap_gnt;
    logic              any_ch, arb_locked;
    logic [IW-1:0]     arb_idx;
    logic [NUM_CH-1:0] full_vec, ch_gnt;

    assign tick     = enable_i && (pre_q == prescale_i);
    assign wrap_evt = tick && (&time_q) && !clear_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q  <= '0;
            time_q <= '0;
        end else if (clear_i) begin
            pre_q  <= '0;
            time_q <= '0;
        end else if (enable_i) begin
            pre_q <= tick ? '0 : pre_q + PRESCALE_WIDTH'(1);
            if (tick) time_q <= time_q + TIMER_WIDTH'(1);
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) full_vec[c] = slot_q[c].full;
    end

    trdb_rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    (full_vec),
        .hold   (stall && !sel_wrap),
        .adv    (accept && !sel_wrap),
        .idx    (arb_idx),
        .any    (any_ch),
        .locked (arb_locked)
    );

    // A channel locked in the arbiter keeps the port even if a wrap arrives.
    assign sel_wrap = wlock_q || (wrap_q && !arb_locked);
    assign valid    = wrap_q || any_ch;
    assign accept   = valid && grant_i;
    assign stall    = valid && !grant_i;
    assign wrap_gnt = accept && sel_wrap;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            ch_gnt[c] = accept && !sel_wrap && (arb_idx == IW'(c));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wlock_q <= 1'b0;
        end else if (accept) begin
            wlock_q <= 1'b0;
        end else if (stall) begin
            wlock_q <= sel_wrap;
        end
    end

    // A slot being granted this cycle may be refilled in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q <= '0;
            wrap_q <= 1'b0;
            drop_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (req_i[c] && (!slot_q[c].full || ch_gnt[c])) begin
                    slot_q[c].full <= 1'b1;
                    slot_q[c].ts   <= time_q;
                end else if (ch_gnt[c]) begin
                    slot_q[c].full <= 1'b0;
                end
                drop_q[c] <= req_i[c] && slot_q[c].full && !ch_gnt[c];
            end
            wrap_q         <= wrap_evt || (wrap_q && !wrap_gnt);
            drop_q[NUM_CH] <= wrap_evt && wrap_q && !wrap_gnt;
        end
    end

    always_comb begin
        time_o = '0;
        ch_o   = '0;
        if (valid && sel_wrap) begin
            ch_o = CH_W'(NUM_CH);
        end else if (valid) begin
            ch_o   = CH_W'(arb_idx);
            time_o = slot_q[arb_idx].ts;
        end
    end

    assign valid_o     = valid;
    assign busy_o      = full_vec;
    assign drop_o      = drop_q;
    assign trdb_time_o = time_q;

endmodule

// File: tb/tb_trdb_timestamp_unit.sv
// Directed bench for trdb_timestamp_unit; a monitor checks granted packets
// against a queue of expected packets filled by the stimulus.
module tb_trdb_timestamp_unit;

    localparam int TW = 8;
    localparam int NC = 2;
    localparam int PW = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0, clear = 1'b0, grant = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic [NC-1:0] req = '0;
    logic [NC-1:0] busy;
    logic [NC:0]   drop;
    logic          valid;
    logic [TW-1:0] time_v, trdb_time;
    logic [CW-1:0] ch;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [TW-1:0] ts;
    } pkt_t;

    pkt_t exp_q[$];
    pkt_t mon_e;
    int   n_cmp = 0, n_bad = 0, mon_cmp = 0, mon_bad = 0;

    always #5 clk = ~clk;

    trdb_timestamp_unit #(
        .TIMER_WIDTH(TW), .NUM_CH(NC), .PRESCALE_WIDTH(PW), .CH_W(CW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .enable_i   (enable),
        .clear_i    (clear),
        .prescale_i (prescale),
        .req_i      (req),
        .busy_o     (busy),
        .drop_o     (drop),
        .valid_o    (valid),
        .grant_i    (grant),
        .time_o     (time_v),
        .ch_o       (ch),
        .trdb_time_o(trdb_time)
    );

    always @(negedge clk) begin
        if (rst_n && valid && grant) begin
            mon_cmp++;
            if (exp_q.size() == 0) begin
                mon_bad++;
                $display("FAIL pkt_unexpected: got ch=%0d time=%0h, required no packet", ch, time_v);
            end else begin
                mon_e = exp_q.pop_front();
                if (ch !== mon_e.ch || time_v !== mon_e.ts) begin
                    mon_bad++;
                    $display("FAIL pkt: got ch=%0d time=%0h, required ch=%0d time=%0h",
                             ch, time_v, mon_e.ch, mon_e.ts);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input int t);
        exp_q.push_back({CW'(c), TW'(t)});
    endtask

    // Runs the timer (prescale 0) until it reads t, then freezes it.
    task automatic run_to(input logic [TW-1:0] t);
        int n;
        n = 0;
        enable = 1'b1;
        while (trdb_time !== t && n < 600) begin
            tick();
            n++;
        end
        enable = 1'b0;
        if (n >= 600) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_to: got timer %0h, required %0h", trdb_time, t);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        #3;
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop, 0);
        chk("rst_time", time_v, 0);
        chk("rst_ch", ch, 0);
        chk("rst_trdb_time", trdb_time, 0);
        #9 rst_n = 1'b1;
        tick();

        // prescale 3: one tick every 4 cycles
        prescale = 8'd3;
        enable   = 1'b1;
        repeat (3) tick();
        chk("pre_3cyc", trdb_time, 0);
        tick();
        chk("pre_4cyc", trdb_time, 1);
        repeat (16) tick();
        chk("pre_20cyc", trdb_time, 5);
        enable = 1'b0;
        repeat (5) tick();
        chk("pre_frozen", trdb_time, 5);
        prescale = '0;

        // capture and one-cycle latency
        run_to(8'h10);
        req = 2'b10;
        push(1, 'h10);
        tick();
        req = '0;
        chk("cap_valid", valid, 1);
        chk("cap_ch", ch, 1);
        chk("cap_time", time_v, 'h10);
        chk("cap_busy", busy, 2'b10);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        chk("cap_valid_after", valid, 0);
        chk("cap_busy_after", busy, 0);

        // stall and drop
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_time", trdb_time, 0);
        run_to(8'd5);
        req = 2'b01;
        push(0, 5);
        tick();
        req = '0;
        run_to(8'd9);
        req = 2'b11;
        push(1, 9);
        tick();
        req = '0;
        chk("stall_drop", drop, 3'b001);
        chk("stall_time", time_v, 5);
        chk("stall_ch", ch, 0);
        chk("stall_busy", busy, 2'b11);
        tick();
        chk("stall_drop_end", drop, 0);
        chk("stall_ch_hold", ch, 0);
        grant = 1'b1;
        tick();
        tick();
        grant = 1'b0;
        chk("stall_drained", valid, 0);

        // round robin, back-to-back grants
        run_to(8'h20);
        req = 2'b11;
        push(0, 'h20);
        push(1, 'h20);
        tick();
        req = '0;
        grant = 1'b1;
        tick();
        tick();
        grant = 1'b0;
        chk("rr_drained", valid, 0);
        run_to(8'h21);
        req = 2'b11;
        push(0, 'h21);
        push(1, 'h21);
        tick();
        req = '0;
        chk("rr_restart_ch", ch, 0);
        grant = 1'b1;
        tick();
        tick();
        grant = 1'b0;

        // clear coincident with tick leaves pending slot intact
        run_to(8'h40);
        req = 2'b01;
        push(0, 'h40);
        tick();
        req = '0;
        enable = 1'b1;
        clear  = 1'b1;
        tick();
        clear  = 1'b0;
        enable = 1'b0;
        chk("clr_tick_time", trdb_time, 0);
        chk("clr_slot_time", time_v, 'h40);
        chk("clr_slot_busy", busy, 2'b01);
        grant = 1'b1;
        tick();
        grant = 1'b0;

        // wrap marker, priority and drop
        run_to(8'hFF);
        run_to(8'h00);
        push(2, 0);
        chk("wrap_valid", valid, 1);
        chk("wrap_ch", ch, 2);
        chk("wrap_time", time_v, 0);
        chk("wrap_nodrop", drop, 0);
        run_to(8'h30);
        req = 2'b10;
        push(1, 'h30);
        tick();
        req = '0;
        chk("wrap_prio_ch", ch, 2);
        chk("wrap_busy", busy, 2'b10);
        run_to(8'hFF);
        run_to(8'h00);
        chk("wrap_drop", drop, 3'b100);
        tick();
        chk("wrap_drop_end", drop, 0);
        grant = 1'b1;
        tick();
        chk("wrap_next_ch", ch, 1);
        tick();
        grant = 1'b0;
        chk("wrap_drained", valid, 0);

        // asynchronous reset while stalled
        run_to(8'h50);
        req = 2'b01;
        tick();
        req = '0;
        chk("arst_pre_valid", valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_time", trdb_time, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("arst_valid_after", valid, 0);
        chk("queue_empty", exp_q.size(), 0);

        n_cmp += mon_cmp;
        n_bad += mon_bad;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
